// File: rtl/fp_norm_round_if.sv
// Upstream/downstream bundle for the binary64 normalise/round stage.
// master drives operands and out_ready; slave is the rounding stage itself.
interface fp_norm_round_if #(
   parameter int EXP_W  = 11,
   parameter int FRAC_W = 52
);
   logic                      in_valid;
   logic                      in_ready;
   logic                      in_sign;
   logic [EXP_W-1:0]          in_exp;
   logic [FRAC_W+1:0]         in_mant;
   logic [2:0]                in_grs;
   logic                      in_add;
   logic [6:0]                in_shift;

   logic                      out_valid;
   logic                      out_ready;
   logic [EXP_W+FRAC_W:0]     out_result;
   logic                      out_ovf;
   logic                      out_unf;
   logic                      out_inx;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, in_grs, in_add, in_shift, out_ready,
      input  in_ready, out_valid, out_result, out_ovf, out_unf, out_inx
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, in_grs, in_add, in_shift, out_ready,
      output in_ready, out_valid, out_result, out_ovf, out_unf, out_inx
   );
endinterface

// File: rtl/fp_norm_round.sv
// Binary64 post-add normalise, round-to-nearest-even and pack; two-stage valid/ready pipeline.
// Build option FP_SUBNORM_EN: emit gradual-underflow subnormals instead of flushing tiny results to zero.
module fp_norm_round #(
   parameter int EXP_W  = 11,
   parameter int FRAC_W = 52
) (
   input  logic           clk,
   input  logic           rst_n,
   fp_norm_round_if.slave bus
);
   localparam int SIG_W  = FRAC_W + 1;
   localparam int MANT_W = FRAC_W + 2;
   localparam int VEC_W  = SIG_W + 3;
   localparam int XEXP_W = EXP_W + 2;
   localparam int SH_W   = 7;
   localparam int RES_W  = EXP_W + FRAC_W + 1;
   localparam logic [XEXP_W-1:0] EXP_INF = XEXP_W'((1 << EXP_W) - 1);

   logic              s1_en;
   logic              s2_en;
   logic              s1_load;
   logic              s2_load;

   logic              s1_v_q, s1_v_d;
   logic              s1_sign_q, s1_sign_d;
   logic [XEXP_W-1:0] s1_exp_q, s1_exp_d;
   logic [SIG_W-1:0]  s1_sig_q, s1_sig_d;
   logic [2:0]        s1_grs_q, s1_grs_d;
   logic              s1_zero_q, s1_zero_d;

   logic              s2_v_q, s2_v_d;
   logic [RES_W-1:0]  res_q, res_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              inx_q, inx_d;

   logic [VEC_W-1:0]  sub_vec;
   logic [XEXP_W-1:0] n_exp;
   logic [SIG_W-1:0]  n_sig;
   logic [2:0]        n_grs;
   logic              n_zero;

   logic [SIG_W-1:0]  rnd_sig;
   logic [2:0]        rnd_grs;
   logic              round_up;
   logic              inexact;
   logic [FRAC_W:0]   frac_sum;
   logic              frac_c;
   logic              carry_out;
   logic [XEXP_W-1:0] fin_exp;

`ifdef FP_SUBNORM_EN
   logic              tiny;
   logic [XEXP_W-1:0] den_amt;
   logic [SH_W-1:0]   den_sh;
   logic [VEC_W-1:0]  den_vec;
   logic [VEC_W-1:0]  den_out;
   logic              den_lost;
`endif

   assign s2_en        = !s2_v_q || bus.out_ready;
   assign s1_en        = !s1_v_q || s2_en;
   assign s1_load      = s1_en && bus.in_valid;
   assign s2_load      = s2_en && s1_v_q;
   assign bus.in_ready = rst_n && s1_en;

   // S1: align the raw sum so the hidden bit sits at sig[FRAC_W]
   always_comb begin
      sub_vec = {bus.in_mant[SIG_W-1:0], bus.in_grs} << bus.in_shift;
      if (bus.in_add) begin
         if (bus.in_shift == SH_W'(1)) begin
            n_sig = bus.in_mant[MANT_W-1:1];
            n_grs = {bus.in_mant[0], bus.in_grs[2], |bus.in_grs[1:0]};
            n_exp = XEXP_W'(bus.in_exp) + XEXP_W'(1);
         end else begin
            n_sig = bus.in_mant[SIG_W-1:0];
            n_grs = bus.in_grs;
            n_exp = XEXP_W'(bus.in_exp);
         end
      end else begin
         n_sig = sub_vec[VEC_W-1:3];
         n_grs = sub_vec[2:0];
         n_exp = XEXP_W'(bus.in_exp) - XEXP_W'(bus.in_shift);
      end
      n_zero = (bus.in_shift == SH_W'(MANT_W - 1)) && (bus.in_mant == '0);

      s1_v_d    = s1_en ? bus.in_valid : s1_v_q;
      s1_sign_d = s1_load ? bus.in_sign : s1_sign_q;
      s1_exp_d  = s1_load ? n_exp : s1_exp_q;
      s1_sig_d  = s1_load ? n_sig : s1_sig_q;
      s1_grs_d  = s1_load ? n_grs : s1_grs_q;
      s1_zero_d = s1_load ? n_zero : s1_zero_q;
   end

   // S2: round to nearest even, then classify and pack
   always_comb begin
      rnd_sig = s1_sig_q;
      rnd_grs = s1_grs_q;
`ifdef FP_SUBNORM_EN
      tiny     = s1_exp_q[XEXP_W-1] || (s1_exp_q == '0);
      den_amt  = XEXP_W'(1) - s1_exp_q;
      den_sh   = (den_amt > XEXP_W'(VEC_W)) ? SH_W'(VEC_W) : den_amt[SH_W-1:0];
      den_vec  = {s1_sig_q, s1_grs_q};
      den_out  = den_vec >> den_sh;
      den_lost = |(den_vec & ~({VEC_W{1'b1}} << den_sh));
      if (tiny) begin
         rnd_sig = den_out[VEC_W-1:3];
         rnd_grs = {den_out[2:1], den_out[0] | den_lost};
      end
`endif
      inexact   = |rnd_grs;
      round_up  = rnd_grs[2] && (rnd_grs[1] || rnd_grs[0] || rnd_sig[0]);
      frac_sum  = {1'b0, rnd_sig[FRAC_W-1:0]} + SIG_W'(round_up);
      frac_c    = frac_sum[FRAC_W];
      // all-ones significand rounding up: fraction wraps to zero, exponent bumps
      carry_out = rnd_sig[FRAC_W] && frac_c;
      fin_exp   = s1_exp_q + XEXP_W'(carry_out);

      res_d = {s1_sign_q, fin_exp[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
      ovf_d = 1'b0;
      unf_d = 1'b0;
      inx_d = inexact;
      if (s1_zero_q) begin
         res_d = '0;
         inx_d = 1'b0;
      end else if (!fin_exp[XEXP_W-1] && (fin_exp >= EXP_INF)) begin
         res_d = {s1_sign_q, EXP_INF[EXP_W-1:0], FRAC_W'(0)};
         ovf_d = 1'b1;
         inx_d = 1'b1;
      end
`ifdef FP_SUBNORM_EN
      else if (tiny) begin
         res_d = {s1_sign_q, EXP_W'(frac_c), frac_sum[FRAC_W-1:0]};
         unf_d = inexact;
      end
`else
      else if (fin_exp[XEXP_W-1] || (fin_exp == '0)) begin
         res_d = {s1_sign_q, (RES_W-1)'(0)};
         unf_d = 1'b1;
         inx_d = 1'b1;
      end
`endif

      s2_v_d = s2_en ? s1_v_q : s2_v_q;
      if (!s2_load) begin
         res_d = res_q;
         ovf_d = ovf_q;
         unf_d = unf_q;
         inx_d = inx_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v_q    <= 1'b0;
         s1_sign_q <= 1'b0;
         s1_exp_q  <= '0;
         s1_sig_q  <= '0;
         s1_grs_q  <= '0;
         s1_zero_q <= 1'b0;
         s2_v_q    <= 1'b0;
         res_q     <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         inx_q     <= 1'b0;
      end else begin
         s1_v_q    <= s1_v_d;
         s1_sign_q <= s1_sign_d;
         s1_exp_q  <= s1_exp_d;
         s1_sig_q  <= s1_sig_d;
         s1_grs_q  <= s1_grs_d;
         s1_zero_q <= s1_zero_d;
         s2_v_q    <= s2_v_d;
         res_q     <= res_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         inx_q     <= inx_d;
      end
   end

   assign bus.out_valid  = s2_v_q;
   assign bus.out_result = res_q;
   assign bus.out_ovf    = ovf_q;
   assign bus.out_unf    = unf_q;
   assign bus.out_inx    = inx_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Bench for fp_norm_round: directed corner cases plus random beats scored against an arithmetic RNE model.
module tb_fp_norm_round;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   fp_norm_round_if bus ();

   fp_norm_round dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic        sign;
      logic [10:0] exp;
      logic [53:0] mant;
      logic [2:0]  grs;
      logic        add;
      logic [6:0]  shift;
   } beat_t;

   task automatic check_val(input string tag, input logic [66:0] got, input logic [66:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic beat_t mk(input logic sign, input logic [10:0] exp, input logic [53:0] mant,
                                input logic [2:0] grs, input logic add, input logic [6:0] shift);
      beat_t b;
      b.sign  = sign;
      b.exp   = exp;
      b.mant  = mant;
      b.grs   = grs;
      b.add   = add;
      b.shift = shift;
      return b;
   endfunction

   task automatic drive(input beat_t b);
      bus.in_sign  = b.sign;
      bus.in_exp   = b.exp;
      bus.in_mant  = b.mant;
      bus.in_grs   = b.grs;
      bus.in_add   = b.add;
      bus.in_shift = b.shift;
   endtask

   function automatic logic [66:0] observed();
      return {bus.out_ovf, bus.out_unf, bus.out_inx, bus.out_result};
   endfunction

   // Value = {mant,grs} * 2^(exp-bias-55); rescale to a 53-bit significand at the target exponent and round.
   function automatic logic [66:0] model(input beat_t b);
      logic [127:0] w, q, rem, half;
      int           k, e, sh;
      logic         inx;
      if (b.shift == 7'd53 && b.mant == 54'd0) return 67'd0;
      w = 128'({b.mant, b.grs});
      if (b.add) k = (b.shift == 7'd1) ? 1 : 0;
      else       k = -int'(b.shift);
      e  = int'(b.exp) + k;
      sh = 3 + k;
`ifdef FP_SUBNORM_EN
      if (e <= 0) sh = sh + 1 - e;
`endif
      if (sh > 0) begin
         q    = w >> sh;
         rem  = w - (q << sh);
         half = 128'd1 << (sh - 1);
      end else begin
         q    = w << (-sh);
         rem  = 128'd0;
         half = 128'd0;
      end
      inx = (rem != 128'd0);
      if (rem > half || (inx && rem == half && q[0])) q = q + 128'd1;
`ifdef FP_SUBNORM_EN
      if (e <= 0) return {1'b0, inx, inx, b.sign, (q[52] ? 11'd1 : 11'd0), q[51:0]};
`endif
      if (q[53]) begin
         q = q >> 1;
         e = e + 1;
      end
      if (e >= 2047) return {3'b101, b.sign, 11'h7FF, 52'd0};
      if (e <= 0)    return {3'b011, b.sign, 63'd0};
      return {2'b00, inx, b.sign, e[10:0], q[51:0]};
   endfunction

   function automatic beat_t gen();
      beat_t b;
      int    kind, s;
      b.sign  = 1'($urandom);
      b.grs   = 3'($urandom);
      b.mant  = 54'({$urandom, $urandom});
      b.exp   = 11'($urandom_range(1, 2046));
      if ($urandom_range(0, 7) == 0) b.exp = 11'($urandom_range(2040, 2046));
      b.add   = 1'b0;
      b.shift = 7'd0;
      kind    = $urandom_range(0, 4);
      case (kind)
         0: begin
            b.add     = 1'b1;
            b.mant[53] = 1'b1;
            b.shift   = 7'd1;
         end
         1: begin
            b.add         = 1'b1;
            b.mant[53:52] = 2'b01;
         end
         2, 3: begin
            s = $urandom_range(0, 52);
            b.mant = b.mant & ((54'd1 << (52 - s)) - 54'd1);
            b.mant[52 - s] = 1'b1;
            b.shift = 7'(s);
            if (kind == 3) b.exp = 11'($urandom_range(1, 60));
         end
         default: begin
            case ($urandom_range(0, 2))
               0: begin
                  b.mant  = 54'd0;
                  b.grs   = 3'd0;
                  b.shift = 7'd53;
               end
               1: begin
                  b.mant[53:52] = 2'b01;
                  b.grs         = 3'b100;
               end
               default: begin
                  b.mant   = {2'b01, {52{1'b1}}};
                  b.grs[2] = 1'b1;
               end
            endcase
         end
      endcase
      return b;
   endfunction

   task automatic directed(input string tag, input beat_t b, input logic [66:0] want);
      @(posedge clk); #1;
      drive(b);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check_val({tag, "_rdy"}, 67'(bus.in_ready), 67'(1));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_val({tag, "_early"}, 67'(bus.out_valid), 67'(0));
      @(posedge clk); #1;
      @(negedge clk);
      check_val({tag, "_vld"}, 67'(bus.out_valid), 67'(1));
      check_val(tag, observed(), want);
   endtask

   task automatic backpressure();
      beat_t       bq[3];
      logic [66:0] bx[3];
      int          sent = 0;
      int          got  = 0;
      logic        acc  = 1'b0;
      bq[0] = mk(1'b0, 11'd1023, 54'h20000000000000, 3'b000, 1'b1, 7'd1);
      bq[1] = mk(1'b0, 11'd1023, 54'h08000000000000, 3'b000, 1'b0, 7'd1);
      bq[2] = mk(1'b0, 11'd1023, 54'h10000000000001, 3'b100, 1'b0, 7'd0);
      bx[0] = {3'b000, 64'h4000000000000000};
      bx[1] = {3'b000, 64'h3FE0000000000000};
      bx[2] = {3'b001, 64'h3FF0000000000002};
      for (int cyc = 0; cyc < 16; cyc++) begin
         @(posedge clk); #1;
         if (acc) sent++;
         if (sent < 3) begin
            drive(bq[sent]);
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         bus.out_ready = (cyc >= 6);
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         if (cyc == 2) check_val("bp_stall", 67'(bus.in_ready), 67'(0));
         if (cyc == 5) begin
            check_val("bp_stall_late", 67'(bus.in_ready), 67'(0));
            check_val("bp_hold", observed(), bx[0]);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (got < 3) check_val($sformatf("bp_res%0d", got), observed(), bx[got]);
            got++;
         end
      end
      check_val("bp_count", 67'(got), 67'(3));
   endtask

   task automatic random_phase(input int n_beats);
      beat_t       cur;
      logic [66:0] sb[$];
      logic [66:0] want;
      logic        acc  = 1'b0;
      int          sent = 0;
      int          recv = 0;
      cur = gen();
      for (int cyc = 0; cyc < 20 * n_beats; cyc++) begin
         @(posedge clk); #1;
         if (acc || !bus.in_valid) begin
            if (sent < n_beats && $urandom_range(0, 3) != 0) begin
               cur = gen();
               drive(cur);
               bus.in_valid = 1'b1;
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         if (acc) begin
            sb.push_back(model(cur));
            sent++;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check_val("rand_spurious", 67'(1), 67'(0));
            end else begin
               want = sb.pop_front();
               check_val($sformatf("rand%0d", recv), observed(), want);
            end
            recv++;
         end
         if (recv >= n_beats && sent >= n_beats) break;
      end
      bus.in_valid = 1'b0;
      check_val("rand_done", 67'(recv), 67'(n_beats));
   endtask

   task automatic reset_mid_flight();
      int seen = 0;
      @(posedge clk); #1;
      drive(mk(1'b0, 11'd1023, 54'h20000000000000, 3'b000, 1'b1, 7'd1));
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      @(negedge clk);
      check_val("midrst_rdy", 67'(bus.in_ready), 67'(0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
         @(posedge clk); #1;
      end
      check_val("midrst_drop", 67'(seen), 67'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive(mk(1'b0, 11'd0, 54'd0, 3'd0, 1'b0, 7'd0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_in_ready", 67'(bus.in_ready), 67'(0));
      check_val("rst_out_valid", 67'(bus.out_valid), 67'(0));
      check_val("rst_result", observed(), 67'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_val("post_rst_ready", 67'(bus.in_ready), 67'(1));

      directed("one_plus_one", mk(1'b0, 11'd1023, 54'h20000000000000, 3'b000, 1'b1, 7'd1),
               {3'b000, 64'h4000000000000000});
      directed("sub_1p5_1", mk(1'b0, 11'd1023, 54'h08000000000000, 3'b000, 1'b0, 7'd1),
               {3'b000, 64'h3FE0000000000000});
      directed("x_minus_x", mk(1'b1, 11'd1023, 54'd0, 3'b000, 1'b0, 7'd53),
               {3'b000, 64'h0000000000000000});
      directed("overflow", mk(1'b0, 11'd2046, 54'h20000000000000, 3'b000, 1'b1, 7'd1),
               {3'b101, 64'h7FF0000000000000});
      directed("tie_even", mk(1'b0, 11'd1023, 54'h10000000000000, 3'b100, 1'b0, 7'd0),
               {3'b001, 64'h3FF0000000000000});
      directed("tie_odd", mk(1'b0, 11'd1023, 54'h10000000000001, 3'b100, 1'b0, 7'd0),
               {3'b001, 64'h3FF0000000000002});
      directed("carry_out", mk(1'b0, 11'd1023, {2'b01, {52{1'b1}}}, 3'b100, 1'b0, 7'd0),
               {3'b001, 64'h4000000000000000});
`ifdef FP_SUBNORM_EN
      directed("tiny", mk(1'b1, 11'd10, 54'h00000100000000, 3'b000, 1'b0, 7'd20),
               {3'b000, 64'h8000020000000000});
`else
      directed("tiny", mk(1'b1, 11'd10, 54'h00000100000000, 3'b000, 1'b0, 7'd20),
               {3'b011, 64'h8000000000000000});
`endif

      backpressure();
      random_phase(400);
      reset_mid_flight();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
